// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for a request, or stepping through operand bits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a requesting datapath (master) and the
// serial adder controller (slave). The Ovf signal exists only when
// SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Cin, input busy, done, S, Cout, Ovf);
  modport slave  (input start, A, B, Cin, output busy, done, S, Cout, Ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, S, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
`endif

endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder, the single arithmetic cell shared across
// all operand bits by the serial adder controller.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures A, B and Cin on start, then feeds
// one fa_cell LSB first, one bit per clock, and publishes {Cout,S} with a
// one-cycle done pulse. Define SERIAL_ADD_OVF_EN to add the signed-overflow
// output Ovf and its operand-MSB capture registers.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  // Holds the WIDTH-1 sum bits produced before the final one.
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-1:0] s_next;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             done_q;
  logic             cell_s, cell_co;
  logic             accept, last_bit;

  fa_cell u_fa_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_CNT);
  // Sum register after this cycle's bit enters at the MSB.
  assign s_next   = {cell_s, s_sr};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept a request in IDLE, return after the last bit.
  always_comb begin
    // NOTE: the default assignment first guarantees no latch on any path.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shifting, carry/count tracking and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are reset too, so an aborted operation
      // leaves no partial state behind.
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (accept) begin
        a_sr    <= bus.A;
        b_sr    <= bus.B;
        s_sr    <= '0;
        carry_q <= bus.Cin;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
        s_sr    <= s_next[WIDTH-1:1];
        carry_q <= cell_co;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_bit) begin
          s_q    <= s_next;
          cout_q <= cell_co;
        end
      end
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Signed overflow: like-signed operands whose sum flips sign. The last
  // cell sum bit is the final S MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= bus.A[WIDTH-1];
        b_msb_q <= bus.B[WIDTH-1];
      end
      if (last_bit) ovf_q <= (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
    end
  end

  assign bus.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Results are predicted
// with plain integer arithmetic; Ovf is checked when SERIAL_ADD_OVF_EN is set.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned sum over W+1 bits.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[W:0];
  endfunction

  // Reference: signed result out of the representable W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sa + sb + int'(cin);
    return (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
  endfunction

  task automatic scramble_inputs();
    bus.A   = W'($urandom);
    bus.B   = W'($urandom);
    bus.Cin = 1'($urandom);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++;
    if (bus.S !== '0) begin failures++; $display("FAIL reset_S got %h exp 00", bus.S); end
    checks++;
    if (bus.Cout !== 1'b0) begin failures++; $display("FAIL reset_Cout got %b exp 0", bus.Cout); end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (bus.Ovf !== 1'b0) begin failures++; $display("FAIL reset_Ovf got %b exp 0", bus.Ovf); end
`endif
    rst = 1'b0;
  endtask

  // One operation; glitch_cyc>0 raises start (with A=B=FF) so edge glitch_cyc
  // samples it while the operation is running, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int glitch_cyc, input string tag);
    logic [W:0] exp_sum;
    logic       exp_ovf;
    int         first_done;
    int         n_done;
    exp_sum = ref_sum(a, b, cin);
    exp_ovf = ref_ovf(a, b, cin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    first_done = -1;
    n_done     = 0;
    for (int k = 1; k <= W + 3; k++) begin
      if (k == glitch_cyc) begin
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'hFF;
        bus.Cin   = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      scramble_inputs();
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done < 0) begin
          first_done = k;
          checks++;
          if (bus.S !== exp_sum[W-1:0]) begin
            failures++;
            $display("FAIL %s_S got %h exp %h", tag, bus.S, exp_sum[W-1:0]);
          end
          checks++;
          if (bus.Cout !== exp_sum[W]) begin
            failures++;
            $display("FAIL %s_Cout got %b exp %b", tag, bus.Cout, exp_sum[W]);
          end
`ifdef SERIAL_ADD_OVF_EN
          checks++;
          if (bus.Ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s_Ovf got %b exp %b", tag, bus.Ovf, exp_ovf);
          end
`endif
        end
      end
      checks++;
      if (bus.busy !== (k < W)) begin
        failures++;
        $display("FAIL %s_busy cycle %0d got %b exp %b", tag, k, bus.busy, (k < W));
      end
    end
    checks++;
    if (first_done != W) begin
      failures++;
      $display("FAIL %s_latency got %0d exp %0d", tag, first_done, W);
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL %s_done_count got %0d exp 1", tag, n_done);
    end
    // Results must hold after the done pulse.
    checks++;
    if (bus.S !== exp_sum[W-1:0]) begin
      failures++;
      $display("FAIL %s_S_hold got %h exp %h", tag, bus.S, exp_sum[W-1:0]);
    end
  endtask

  task automatic test_directed();
    run_op(8'hFF, 8'h01, 1'b0, 0, "ff_01");
    run_op(8'h3C, 8'h42, 1'b1, 0, "3c_42");
    run_op(8'h7F, 8'h01, 1'b0, 0, "7f_01");
    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
    run_op(8'hFF, 8'hFF, 1'b1, 0, "max");
  endtask

  task automatic test_ignore_start();
    run_op(8'h10, 8'h20, 1'b0, 3, "ignore_start");
  endtask

  task automatic test_reset_abort();
    int n_done;
    run_op(8'hC3, 8'h5A, 1'b1, 0, "pre_abort");
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'h55;
    bus.B     = 8'h0F;
    bus.Cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b exp 1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got %b exp 0", bus.done); end
    checks++;
    if (bus.S !== '0) begin failures++; $display("FAIL abort_S got %h exp 00", bus.S); end
    checks++;
    if (bus.Cout !== 1'b0) begin failures++; $display("FAIL abort_Cout got %b exp 0", bus.Cout); end
    n_done = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin failures++; $display("FAIL abort_no_done got %0d exp 0", n_done); end
    run_op(8'h55, 8'h0F, 1'b0, 0, "post_abort");
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 4;
    logic [2*W:0] pend[$];
    logic [2*W:0] op;
    logic [W:0]   exp_sum;
    logic         exp_done;
    int           n_done;
    n_done = 0;
    for (int e = 0; e < NOPS * (W + 1); e++) begin
      bus.start = 1'b1;
      scramble_inputs();
      op = {bus.Cin, bus.B, bus.A};
      @(posedge clk);
      if (e % (W + 1) == 0) pend.push_back(op);
      @(negedge clk);
      exp_done = (e % (W + 1) == W);
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done edge %0d got %b exp %b", e, bus.done, exp_done);
      end
      checks++;
      if (bus.busy !== !exp_done) begin
        failures++;
        $display("FAIL b2b_busy edge %0d got %b exp %b", e, bus.busy, !exp_done);
      end
      if (bus.done === 1'b1 && pend.size() > 0) begin
        op = pend.pop_front();
        n_done++;
        exp_sum = ref_sum(op[W-1:0], op[2*W-1:W], op[2*W]);
        checks++;
        if ({bus.Cout, bus.S} !== exp_sum) begin
          failures++;
          $display("FAIL b2b_result edge %0d got %h exp %h", e, {bus.Cout, bus.S}, exp_sum);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (bus.Ovf !== ref_ovf(op[W-1:0], op[2*W-1:W], op[2*W])) begin
          failures++;
          $display("FAIL b2b_Ovf edge %0d got %b exp %b", e, bus.Ovf,
                   ref_ovf(op[W-1:0], op[2*W-1:W], op[2*W]));
        end
`endif
      end
    end
    bus.start = 1'b0;
    checks++;
    if (n_done != NOPS) begin
      failures++;
      $display("FAIL b2b_count got %0d exp %0d", n_done, NOPS);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, W - 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time in case the design never finishes an operation.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in on a start strobe, then sequences a single 1-bit full-adder cell across the operand bits, LSB first, one bit per clock. It presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the shared 1-bit adder cell, trading latency for area in the team's arithmetic blocks.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request strobe; sampled only in IDLE
- A  input  WIDTH  operand A; captured on accepted start
- B  input  WIDTH  operand B; captured on accepted start
- Cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when S/Cout update
- S  output  WIDTH  sum; held until next completion
- Cout  output  1  final carry-out; held until next completion
- Ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN

## Operation
- States: IDLE, RUN.
- IDLE: busy=0. On start=1: load shift registers a_sr←A, b_sr←B, carry←Cin, bit count←0, go RUN.
- RUN: busy=1. Each cycle, the cell adds a_sr[0], b_sr[0], carry. The sum bit shifts into the MSB of s_sr; a_sr, b_sr and s_sr shift right; carry←cell carry-out; count increments.
- On the WIDTH-th bit: S←final s_sr including this bit, Cout←cell carry-out, done←1, state←IDLE.
- start is ignored in RUN; operands may change freely after acceptance.
- Arithmetic: {Cout,S} = A + B + Cin, unsigned, exact over WIDTH+1 bits.
- Reset: state IDLE, busy 0, done 0, S 0, Cout 0, Ovf 0, shift registers/count/carry 0.
- Reset mid-operation aborts the operation: no done pulse and the partial result is discarded. Reset has priority over start.

## Timing
- Edge E0 samples start=1 in IDLE, and busy is high from the cycle after E0.
- Edges E1..E_WIDTH each process one bit.
- At E_WIDTH: S/Cout/Ovf update, done=1 for exactly one cycle, busy=0.
- Latency: done is visible WIDTH cycles after the start-sampling edge.
- Back-to-back: start high during the done cycle is accepted at E_WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- done is never high for two consecutive cycles.

## Configuration
- SERIAL_ADD_OVF_EN defined: the Ovf port exists and updates with S. Ovf = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]), computed from the captured operand MSBs, which are held in a register. Reset value is 0.
- SERIAL_ADD_OVF_EN undefined: no Ovf port and no MSB capture registers. All other behaviour is identical.

## Structure
- Shared package/header: state encoding localparams (ST_IDLE, ST_RUN) and the default WIDTH constant.
- One sub-module, fa_cell: a combinational 1-bit full adder (a, b, ci → s, co). It is instantiated once in the controller.
- The count register width is $clog2(WIDTH+1).

## Test plan
- WIDTH=8: A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, done exactly 8 cycles after the start edge.
- A=8'h3C, B=8'h42, Cin=1 → S=8'h7F, Cout=0, Ovf=0 (with macro).
- A=8'h7F, B=8'h01, Cin=0 → S=8'h80, Cout=0, Ovf=1. Recompile without the macro → same S/Cout, no Ovf port.
- Start A=8'h10, B=8'h20, then pulse start with A=8'hFF, B=8'hFF at cycle 3 → single done, S=8'h30, Cout=0.
- Assert rst in cycle 4 of an operation → busy, done, S and Cout all 0 the next cycle, with no done pulse. A following start completes correctly.
- Hold start=1 continuously with changing operands → done every 9 cycles, each result matches the operands sampled at its accepting edge.
